// File: rtl/r_rp_add_clocked.sv
// Registered carry-free adder for radix-RADIX signed digits in {-(RADIX-1)..RADIX-1}.
// Define RRP_ADD_CLAMP_EN to clamp the out-of-set input code -RADIX to -(RADIX-1).
module r_rp_add_clocked #(
   parameter int RADIX = 4,
   parameter int WIDTH = 6,
   localparam int D = $clog2(RADIX) + 1,
   localparam int N = D * WIDTH
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic [N-1:0] x_in,
   input  logic [N-1:0] y_in,
   output logic [N+D-1:0] s_out
);

   localparam int A = RADIX - 1;
   localparam int P = D + 2;

   localparam logic signed [P-1:0] A_P   = P'(A);
   localparam logic signed [P-1:0] NEG_A = -P'(A);
   localparam logic signed [P-1:0] R_P   = P'(RADIX);
   localparam logic signed [D-1:0] ONE_D = D'(1);
   localparam logic signed [D-1:0] NEG_ONE_D = '1;

`ifdef RRP_ADD_CLAMP_EN
   localparam logic [D-1:0] MIN_CODE   = {1'b1, {(D-1){1'b0}}};
   localparam logic [D-1:0] NEG_A_CODE = D'(-A);

   function automatic logic [D-1:0] clamp_digit(input logic [D-1:0] d);
      if (d == MIN_CODE) begin
         return NEG_A_CODE;
      end
      return d;
   endfunction
`endif

   function automatic logic signed [P-1:0] ext(input logic [D-1:0] d);
      return P'(signed'(d));
   endfunction

   logic [N-1:0]   x_q;
   logic [N-1:0]   y_q;
   logic [N+D-1:0] s_next;

   logic signed [P-1:0] p [WIDTH];
   logic signed [D-1:0] w [WIDTH];
   logic signed [D-1:0] t [WIDTH+1];

   // Stage 1: operand capture; cleared asynchronously so in-flight data is dropped.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_in;
         y_q <= y_in;
      end
   end

   // Each position emits a transfer of -1/0/+1 into the next position only, so the
   // interim digit plus incoming transfer always stays inside the digit set.
   always_comb begin
      s_next = '0;
      t[0]   = '0;
      for (int i = 0; i < WIDTH; i++) begin
`ifdef RRP_ADD_CLAMP_EN
         p[i] = ext(clamp_digit(x_q[i*D +: D])) + ext(clamp_digit(y_q[i*D +: D]));
`else
         p[i] = ext(x_q[i*D +: D]) + ext(y_q[i*D +: D]);
`endif
         if (p[i] >= A_P) begin
            t[i+1] = ONE_D;
            w[i]   = D'(p[i] - R_P);
         end else if (p[i] <= NEG_A) begin
            t[i+1] = NEG_ONE_D;
            w[i]   = D'(p[i] + R_P);
         end else begin
            t[i+1] = '0;
            w[i]   = D'(p[i]);
         end
      end
      for (int i = 0; i < WIDTH; i++) begin
         s_next[i*D +: D] = w[i] + t[i];
      end
      s_next[WIDTH*D +: D] = t[WIDTH];
   end

   // Stage 2: s_out comes straight from this register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s_out <= '0;
      end else begin
         s_out <= s_next;
      end
   end

endmodule

// File: tb/tb_r_rp_add_clocked.sv
// Self-checking bench for r_rp_add_clocked: directed corner cases plus a random
// stream compared against an integer-value reference model.
module tb_r_rp_add_clocked;

   localparam int RADIX = 4;
   localparam int WIDTH = 6;
   localparam int A  = RADIX - 1;
   localparam int D  = $clog2(RADIX) + 1;
   localparam int N  = D * WIDTH;
   localparam int SN = N + D;

   logic          clock;
   logic          resetn;
   logic [N-1:0]  x_in;
   logic [N-1:0]  y_in;
   logic [SN-1:0] s_out;

   int checks = 0;
   int errors = 0;

   r_rp_add_clocked #(.RADIX(RADIX), .WIDTH(WIDTH)) dut (
      .clock (clock),
      .resetn(resetn),
      .x_in  (x_in),
      .y_in  (y_in),
      .s_out (s_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no summary, required finish");
      $fatal(1, "[TB] timeout");
   end

   function automatic int digit_of(input logic [SN-1:0] v, input int i);
      logic [D-1:0] d;
      d = v[i*D +: D];
      return int'(signed'(d));
   endfunction

   function automatic longint value_of(input logic [SN-1:0] v, input int ndig);
      longint acc;
      longint wgt;
      acc = 0;
      wgt = 1;
      for (int i = 0; i < ndig; i++) begin
         acc += longint'(digit_of(v, i)) * wgt;
         wgt *= RADIX;
      end
      return acc;
   endfunction

   function automatic longint operand_value(input logic [N-1:0] v);
      return value_of({{D{1'b0}}, v}, WIDTH);
   endfunction

   function automatic logic [N-1:0] fill_digits(input int d);
      logic [N-1:0] v;
      v = '0;
      for (int i = 0; i < WIDTH; i++) v[i*D +: D] = d[D-1:0];
      return v;
   endfunction

   function automatic logic [N-1:0] rand_operand();
      logic [N-1:0] v;
      int d;
      v = '0;
      for (int i = 0; i < WIDTH; i++) begin
         d = int'($urandom_range(2*A)) - A;
         v[i*D +: D] = d[D-1:0];
      end
      return v;
   endfunction

   task automatic apply_pair(input logic [N-1:0] x, input logic [N-1:0] y,
                             output logic [SN-1:0] s);
      @(negedge clock);
      x_in = x;
      y_in = y;
      @(posedge clock);
      @(posedge clock);
      #1 s = s_out;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #1;
      checks++;
      if (s_out !== '0) begin
         errors++;
         $display("FAIL reset_initial: s_out=%h required 0", s_out);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         x_in = rand_operand();
         y_in = rand_operand();
         @(posedge clock);
         #1;
         checks++;
         if (s_out !== '0) begin
            errors++;
            $display("FAIL reset_hold[%0d]: s_out=%h required 0", k, s_out);
         end
      end
      @(negedge clock);
      x_in   = '0;
      y_in   = '0;
      resetn = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1;
      checks++;
      if (s_out !== '0) begin
         errors++;
         $display("FAIL reset_zero_sum: s_out=%h required 0", s_out);
      end
   endtask

   task automatic test_extremes();
      logic [SN-1:0] s;
      int exp_pos [WIDTH+1] = '{2, 3, 3, 3, 3, 3, 1};
      int exp_neg [WIDTH+1] = '{-2, -3, -3, -3, -3, -3, -1};
      apply_pair(fill_digits(3), fill_digits(3), s);
      checks++;
      if (value_of(s, WIDTH+1) !== 64'sd8190) begin
         errors++;
         $display("FAIL max_pos_value: got %0d required 8190", value_of(s, WIDTH+1));
      end
      for (int i = 0; i <= WIDTH; i++) begin
         checks++;
         if (digit_of(s, i) !== exp_pos[i]) begin
            errors++;
            $display("FAIL max_pos_digit[%0d]: got %0d required %0d", i, digit_of(s, i), exp_pos[i]);
         end
      end
      apply_pair(fill_digits(-3), fill_digits(-3), s);
      checks++;
      if (value_of(s, WIDTH+1) !== -64'sd8190) begin
         errors++;
         $display("FAIL max_neg_value: got %0d required -8190", value_of(s, WIDTH+1));
      end
      for (int i = 0; i <= WIDTH; i++) begin
         checks++;
         if (digit_of(s, i) !== exp_neg[i]) begin
            errors++;
            $display("FAIL max_neg_digit[%0d]: got %0d required %0d", i, digit_of(s, i), exp_neg[i]);
         end
      end
   endtask

   task automatic test_single_transfer();
      logic [SN-1:0] s;
      logic [N-1:0]  x;
      logic [N-1:0]  y;
      x = '0;
      y = '0;
      x[D-1:0] = D'(2);
      y[D-1:0] = D'(2);
      apply_pair(x, y, s);
      checks++;
      if (value_of(s, WIDTH+1) !== 64'sd4 || digit_of(s, 0) !== 0 || digit_of(s, 1) !== 1) begin
         errors++;
         $display("FAIL transfer_2p2: value=%0d s0=%0d s1=%0d required 4,0,1",
                  value_of(s, WIDTH+1), digit_of(s, 0), digit_of(s, 1));
      end
      x = '0;
      y = '0;
      x[D-1:0] = D'(1);
      y[D-1:0] = '1;
      apply_pair(x, y, s);
      checks++;
      if (value_of(s, WIDTH+1) !== 64'sd0) begin
         errors++;
         $display("FAIL transfer_1m1: value=%0d required 0", value_of(s, WIDTH+1));
      end
   endtask

   // Pair k is driven before edge k; its sum is visible just after edge k+1.
   // A reset pulse after edge rst_at wipes pairs up to rst_at, so that slot expects 0.
   task automatic test_random_stream(input int n, input int rst_at, input string tag);
      longint exp_v [0:255];
      logic [N-1:0] x;
      logic [N-1:0] y;
      bit range_ok;
      int d;
      for (int i = 0; i <= n; i++) begin
         @(negedge clock);
         if (i < n) begin
            x = rand_operand();
            y = rand_operand();
         end else begin
            x = '0;
            y = '0;
         end
         x_in = x;
         y_in = y;
         exp_v[i] = operand_value(x) + operand_value(y);
         @(posedge clock);
         #1;
         if (i >= 1) begin
            checks++;
            if (value_of(s_out, WIDTH+1) !== exp_v[i-1]) begin
               errors++;
               $display("FAIL %s_value[%0d]: got %0d required %0d", tag, i-1,
                        value_of(s_out, WIDTH+1), exp_v[i-1]);
            end
            range_ok = 1'b1;
            for (int j = 0; j < WIDTH; j++) begin
               d = digit_of(s_out, j);
               if (d < -A || d > A) range_ok = 1'b0;
            end
            d = digit_of(s_out, WIDTH);
            if (d < -1 || d > 1) range_ok = 1'b0;
            checks++;
            if (!range_ok) begin
               errors++;
               $display("FAIL %s_digit_range[%0d]: s_out=%h required digits in range", tag, i-1, s_out);
            end
         end
         if (i == rst_at) begin
            #1 resetn = 1'b0;
            #1;
            checks++;
            if (s_out !== '0) begin
               errors++;
               $display("FAIL %s_async_clear: s_out=%h required 0", tag, s_out);
            end
            exp_v[i] = 0;
            #1 resetn = 1'b1;
         end
      end
   endtask

   initial begin
      resetn = 1'b0;
      x_in   = '0;
      y_in   = '0;
      $display("[TB] start");
      test_reset();
      test_extremes();
      test_single_transfer();
      test_random_stream(120, -1, "random");
      test_random_stream(60, 25, "midreset");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
